// File: rtl/dram_arb_pkg.sv
// Shared types for the two-master DRAM arbiter: FSM states, master ids and op codes.
package dram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_id_t;
    typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
endpackage

// File: rtl/dram_arb_pick.sv
// Combinational winner selection between two requesters.
module dram_arb_pick
    import dram_arb_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  master_id_t rr_ptr_i,
    input  logic       rr_enable_i,
    output logic       valid_o,
    output master_id_t winner_o
);
    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = M0;
        if (req0_i && req1_i) begin
            // Contention: round-robin pointer decides, otherwise m0 has fixed priority.
            if (rr_enable_i) begin
                winner_o = rr_ptr_i;
            end
        end else if (req1_i) begin
            winner_o = M1;
        end
    end
endmodule

// File: rtl/dram_arbiter.sv
// Two-master arbiter in front of a combinational-read / single-cycle-write RAM port.
// Each transaction takes IDLE -> ACCESS -> RESPOND; all request fields are latched at grant.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic [ADDR_W-1:0] data_address,
    output logic              data_read,
    output logic              data_write,
    output logic [DATA_W-1:0] data_writedata,
    input  logic [DATA_W-1:0] data_readdata
);
    state_t            state_q, state_d;
    master_id_t        grant_q, grant_d;
    master_id_t        rr_ptr_q, rr_ptr_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic       req0, req1, pick_valid;
    master_id_t pick_winner;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    dram_arb_pick u_pick (
        .req0_i      (req0),
        .req1_i      (req1),
        .rr_ptr_i    (rr_ptr_q),
        .rr_enable_i (RR_ENABLE),
        .valid_o     (pick_valid),
        .winner_o    (pick_winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= M0;
            rr_ptr_q <= M0;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        data_read  = 1'b0;
        data_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_winner;
                    state_d = ACCESS;
                    // A simultaneous read and write strobe is treated as a write.
                    if (pick_winner == M1) begin
                        addr_d  = m1_address;
                        wdata_d = m1_writedata;
                        op_d    = m1_write ? OP_WRITE : OP_READ;
                    end else begin
                        addr_d  = m0_address;
                        wdata_d = m0_writedata;
                        op_d    = m0_write ? OP_WRITE : OP_READ;
                    end
                end
            end
            ACCESS: begin
                data_read  = (op_q == OP_READ);
                data_write = (op_q == OP_WRITE);
                if (op_q == OP_READ) begin
                    rdata_d = data_readdata;
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                rr_ptr_d = (grant_q == M0) ? M1 : M0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_address   = addr_q;
    assign data_writedata = wdata_q;
    assign m0_readdata    = rdata_q;
    assign m1_readdata    = rdata_q;
    // Low only in the granted master's RESPOND cycle, or whenever that master is not requesting.
    assign m0_waitrequest = req0 & ~((state_q == RESPOND) && (grant_q == M0));
    assign m1_waitrequest = req1 & ~((state_q == RESPOND) && (grant_q == M1));
endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: transaction-timeline reference model plus directed and random traffic.
module tb_dram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ram_init = 1'b1;
    logic [31:0] m0_address = '0, m1_address = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_read, data_write;

    logic        fp_m0_wait, fp_m1_wait, fp_dread, fp_dwrite;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_daddr, fp_dwdata, fp_drdata;

    logic [31:0] mem [0:63];
    logic [31:0] shadow [0:63];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.RR_ENABLE(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .data_readdata(data_readdata)
    );

    dram_arbiter #(.RR_ENABLE(1'b0)) u_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(fp_m0_wait), .m0_readdata(fp_m0_rdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(fp_m1_wait), .m1_readdata(fp_m1_rdata),
        .data_address(fp_daddr), .data_read(fp_dread), .data_write(fp_dwrite),
        .data_writedata(fp_dwdata), .data_readdata(fp_drdata)
    );

    function automatic logic [31:0] std_word(input int i);
        if (i == 0) return 32'h78563412;
        if (i == 1) return 32'hAC68EEEE;
        return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
    endfunction

    // RAM: combinational read, write on the clock edge ending the strobe cycle.
    assign data_readdata = mem[data_address[7:2]];
    assign fp_drdata     = mem[fp_daddr[7:2]];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= std_word(i);
        end else if (data_write) begin
            mem[data_address[7:2]] <= data_writedata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant taken at edge g means RAM access between g and g+1,
    // response between g+1 and g+2, and the next grant no earlier than edge g+3.
    int          ecount = 0;
    int          gedge = -100;
    int          rr = 0;
    int          m_gnt = 0;
    bit          m_write = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, exp_rdata = '0;
    int          grant_log [$];

    always @(posedge clk or posedge reset) begin
        bit r0, r1;
        if (ram_init) begin
            for (int i = 0; i < 64; i++) shadow[i] = std_word(i);
        end
        if (reset) begin
            gedge = -100; rr = 0; m_gnt = 0; m_write = 1'b0;
            m_addr = '0; m_wdata = '0; exp_rdata = '0;
        end else begin
            ecount++;
            if (ecount == gedge + 1) begin
                if (m_write) shadow[m_addr[7:2]] = m_wdata;
                else exp_rdata = shadow[m_addr[7:2]];
            end
            if (ecount == gedge + 2) rr = 1 - m_gnt;
            if (ecount >= gedge + 3) begin
                r0 = m0_read | m0_write;
                r1 = m1_read | m1_write;
                if (r0 || r1) begin
                    m_gnt   = (r0 && r1) ? rr : (r1 ? 1 : 0);
                    m_addr  = (m_gnt == 1) ? m1_address : m0_address;
                    m_wdata = (m_gnt == 1) ? m1_writedata : m0_writedata;
                    m_write = (m_gnt == 1) ? m1_write : m0_write;
                    gedge   = ecount;
                    grant_log.push_back(m_gnt);
                end
            end
        end
    end

    always @(negedge clk) begin
        bit in_acc, in_rsp;
        in_acc = (ecount == gedge);
        in_rsp = (ecount == gedge + 1);
        chk("wait0", 32'(m0_waitrequest), 32'((m0_read | m0_write) & !(in_rsp && m_gnt == 0)));
        chk("wait1", 32'(m1_waitrequest), 32'((m1_read | m1_write) & !(in_rsp && m_gnt == 1)));
        chk("rdata0", m0_readdata, exp_rdata);
        chk("rdata1", m1_readdata, exp_rdata);
        chk("dread", 32'(data_read), 32'(in_acc && !m_write));
        chk("dwrite", 32'(data_write), 32'(in_acc && m_write));
        chk("daddr", data_address, m_addr);
        chk("dwdata", data_writedata, m_wdata);
    end

    int wr_strobes = 0;
    bit fp_phase = 1'b0;
    int fp_m0_served = 0, fp_m1_served = 0;
    always @(negedge clk) begin
        if (data_write) wr_strobes++;
        if (fp_phase && (m0_read | m0_write) && !fp_m0_wait) fp_m0_served++;
        if (fp_phase && (m1_read | m1_write) && !fp_m1_wait) fp_m1_served++;
    end

    task automatic set_req(input int m, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = wd;
        end
    endtask

    task automatic wait_done(input int m, output int lat);
        lat = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!((m == 0) ? m0_waitrequest : m1_waitrequest)) return;
            lat++;
        end
        checks++;
        errors++;
        $display("FAIL timeout_m%0d actual=pending required=served", m);
    endtask

    task automatic xfer(input int m, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
        set_req(m, !wr, wr, a, wd);
        wait_done(m, lat);
        rd = (m == 0) ? m0_readdata : m1_readdata;
        $display("xfer m%0d %s addr=%h wdata=%h rdata=%h lat=%0d", m, wr ? "WR" : "RD", a, wd, rd, lat);
        @(posedge clk); #1;
        set_req(m, 1'b0, 1'b0, a, wd);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    logic [31:0] rd0, rd1;
    int          lat0, lat1;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        ram_init = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        chk("reset_rdata0", m0_readdata, 32'h0);
        chk("reset_wait0", 32'(m0_waitrequest), 32'h0);
        @(posedge clk); #1;

        xfer(0, 1'b0, 32'h0, 32'h0, rd0, lat0);
        chk("t1_lat", 32'(lat0), 32'd2);
        chk("t1_data", rd0, 32'h78563412);

        lat1 = wr_strobes;
        xfer(1, 1'b1, 32'h8, 32'hDEADBEEF, rd1, lat0);
        chk("t2_strobes", 32'(wr_strobes - lat1), 32'd1);
        xfer(0, 1'b0, 32'h8, 32'h0, rd0, lat0);
        chk("t2_data", rd0, 32'hDEADBEEF);

        pulse_reset();
        fork
            xfer(0, 1'b0, 32'h0, 32'h0, rd0, lat0);
            xfer(1, 1'b0, 32'h4, 32'h0, rd1, lat1);
        join
        chk("t3_lat0", 32'(lat0), 32'd2);
        chk("t3_lat1", 32'(lat1), 32'd5);
        chk("t3_data0", rd0, 32'h78563412);
        chk("t3_data1", rd1, 32'hAC68EEEE);

        pulse_reset();
        grant_log.delete();
        fp_phase = 1'b1;
        fork
            begin
                logic [31:0] r; int l;
                for (int i = 0; i < 4; i++) xfer(0, 1'b0, 32'h10, 32'h0, r, l);
                fp_phase = 1'b0;
            end
            begin
                logic [31:0] r; int l;
                for (int i = 0; i < 4; i++) xfer(1, 1'b0, 32'h14, 32'h0, r, l);
            end
        join
        chk("t4_ngrants", 32'(grant_log.size() >= 4), 32'd1);
        if (grant_log.size() >= 4) begin
            chk("t4_g0", 32'(grant_log[0]), 32'd0);
            chk("t4_g1", 32'(grant_log[1]), 32'd1);
            chk("t4_g2", 32'(grant_log[2]), 32'd0);
            chk("t4_g3", 32'(grant_log[3]), 32'd1);
        end
        chk("t4_fp_m1", 32'(fp_m1_served), 32'd0);
        chk("t4_fp_m0", 32'(fp_m0_served >= 4), 32'd1);

        set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        m0_address = 32'h4;
        @(negedge clk);
        chk("t5_daddr", data_address, 32'h0);
        wait_done(0, lat0);
        chk("t5_data", m0_readdata, 32'h78563412);
        $display("xfer m0 RD addr changed 0->4 in access rdata=%h", m0_readdata);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);

        set_req(1, 1'b0, 1'b1, 32'hC, 32'h55AA55AA);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_wr_on", 32'(data_write), 32'd1);
        #2 reset = 1'b1;
        #1 chk("t6_wr_async_off", 32'(data_write), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        wait_done(1, lat1);
        chk("t6_reserve_lat", 32'(lat1), 32'd2);
        $display("xfer m1 WR addr=0000000c re-served after reset lat=%0d", lat1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 32'hC, 32'h0);
        xfer(0, 1'b0, 32'hC, 32'h0, rd0, lat0);
        chk("t6_data", rd0, 32'h55AA55AA);

        fork
            for (int i = 0; i < 30; i++) begin
                logic [31:0] r; int l;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                xfer(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom, r, l);
            end
            for (int i = 0; i < 30; i++) begin
                logic [31:0] r; int l;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                xfer(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom, r, l);
            end
        join

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end
endmodule
